// File: rtl/hgame_hand_tx_if.sv
// Handshake and serial-line bundle between player-input logic, hgame_hand_tx and the game core.
`timescale 1ns/1ps
interface hgame_hand_tx_if #(
    parameter int RND_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       hand_a;
    logic [1:0]       hand_b;
    logic [1:0]       hand_c;
    logic             a;
    logic             b;
    logic             c;
    logic             frame_vld;
    logic             frame_err;
    logic [RND_W-1:0] round_cnt;

    modport master (
        output in_valid, hand_a, hand_b, hand_c,
        input  in_ready, a, b, c, frame_vld, frame_err, round_cnt
    );

    modport slave (
        input  in_valid, hand_a, hand_b, hand_c,
        output in_ready, a, b, c, frame_vld, frame_err, round_cnt
    );
endinterface

// File: rtl/hgame_hand_tx.sv
// Serialises one round of three 2-bit hand codes MSB-first onto lines A/B/C with a frame strobe.
// Define HGAME_TX_PARITY_EN to append a per-line odd-parity cycle to each frame.
`timescale 1ns/1ps
module hgame_hand_tx #(
    parameter int GAP_CYCLES = 2,
    parameter int RND_W      = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    hgame_hand_tx_if.slave bus
);
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MSB  = 3'd1,
        LSB  = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cap_a_q, cap_a_d;
    logic [1:0]       cap_b_q, cap_b_d;
    logic [1:0]       cap_c_q, cap_c_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [RND_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             c_q, c_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             to_rest;

`ifdef HGAME_TX_PARITY_EN
    function automatic logic odd_par(input logic [1:0] code);
        return ~(code[1] ^ code[0]);
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cap_a_d = cap_a_q;
        cap_b_d = cap_b_q;
        cap_c_d = cap_c_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        c_d     = 1'b0;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        to_rest = 1'b0;

        unique case (state_q)
            IDLE: begin
                // ready_q is only high in IDLE, so it doubles as the accept qualifier
                if (ready_q && bus.in_valid) begin
                    cap_a_d = bus.hand_a;
                    cap_b_d = bus.hand_b;
                    cap_c_d = bus.hand_c;
                    if ((bus.hand_a != 2'b00) && (bus.hand_b != 2'b00) && (bus.hand_c != 2'b00)) begin
                        state_d = MSB;
                        a_d     = bus.hand_a[1];
                        b_d     = bus.hand_b[1];
                        c_d     = bus.hand_c[1];
                        vld_d   = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        to_rest = 1'b1;
                    end
                end
            end
            MSB: begin
                state_d = LSB;
                a_d     = cap_a_q[0];
                b_d     = cap_b_q[0];
                c_d     = cap_c_q[0];
                vld_d   = 1'b1;
            end
            LSB: begin
`ifdef HGAME_TX_PARITY_EN
                state_d = PAR;
                a_d     = odd_par(cap_a_q);
                b_d     = odd_par(cap_b_q);
                c_d     = odd_par(cap_c_q);
                vld_d   = 1'b1;
`else
                cnt_d   = cnt_q + 1'b1;
                to_rest = 1'b1;
`endif
            end
            PAR: begin
                cnt_d   = cnt_q + 1'b1;
                to_rest = 1'b1;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Down-counter is loaded with GAP_CYCLES-1 so GAP lasts exactly GAP_CYCLES cycles
        if (to_rest) begin
            if (GAP_CYCLES == 0) begin
                state_d = IDLE;
            end else begin
                state_d = GAP;
                gap_d   = GAP_W'(GAP_CYCLES - 1);
            end
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cap_a_q <= 2'b00;
            cap_b_q <= 2'b00;
            cap_c_q <= 2'b00;
            gap_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_a_q <= cap_a_d;
            cap_b_q <= cap_b_d;
            cap_c_q <= cap_c_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.c         = c_q;
    assign bus.frame_vld = vld_q;
    assign bus.frame_err = err_q;
    assign bus.round_cnt = cnt_q;
endmodule

// File: tb/tb_hgame_hand_tx.sv
// Directed bench for hgame_hand_tx: reset, framing, error rejection, input hold, mid-frame reset, counter wrap.
`timescale 1ns/1ps
module tb_hgame_hand_tx;
`ifdef HGAME_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    hgame_hand_tx_if #(.RND_W(4)) bus ();

    hgame_hand_tx #(.GAP_CYCLES(2), .RND_W(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_ready_timeout: got in_ready=%b required 1 within 20 cycles", name, bus.in_ready);
        end
    endtask

    // Observed vector is {a, b, c, frame_vld, in_ready}
    function automatic logic [4:0] obs();
        return {bus.a, bus.b, bus.c, bus.frame_vld, bus.in_ready};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.hand_a = 2'b00;
        bus.hand_b = 2'b00;
        bus.hand_c = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({obs(), bus.frame_err} !== 6'b000000) begin
            n_bad++; $display("FAIL rst_outputs: got %b required 000000", {obs(), bus.frame_err});
        end
        n_cmp++;
        if (bus.round_cnt !== 4'd0) begin
            n_bad++; $display("FAIL rst_cnt: got %0d required 0", bus.round_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if ({obs(), bus.frame_err} !== 6'b000010) begin
            n_bad++; $display("FAIL post_rst_idle: got %b required 000010", {obs(), bus.frame_err});
        end
        n_cmp++;
        if (bus.round_cnt !== 4'd0) begin
            n_bad++; $display("FAIL post_rst_cnt: got %0d required 0", bus.round_cnt);
        end
    endtask

    task automatic test_frame();
        wait_ready("frame");
        bus.in_valid = 1'b1;
        bus.hand_a = 2'b01; bus.hand_b = 2'b10; bus.hand_c = 2'b11;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (obs() !== 5'b01110) begin
            n_bad++; $display("FAIL frame_msb: got %b required 01110", obs());
        end
        tick();
        n_cmp++;
        if (obs() !== 5'b10110) begin
            n_bad++; $display("FAIL frame_lsb: got %b required 10110", obs());
        end
        if (P == 1) begin
            tick();
            n_cmp++;
            if (obs() !== 5'b00110) begin
                n_bad++; $display("FAIL frame_par: got %b required 00110", obs());
            end
        end
        tick();
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL frame_gap1: got %b required 00000", obs());
        end
        n_cmp++;
        if (bus.round_cnt !== 4'd1) begin
            n_bad++; $display("FAIL frame_cnt: got %0d required 1", bus.round_cnt);
        end
        tick();
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL frame_gap2: got %b required 00000", obs());
        end
        tick();
        n_cmp++;
        if (obs() !== 5'b00001) begin
            n_bad++; $display("FAIL frame_idle: got %b required 00001", obs());
        end
    endtask

    task automatic test_error();
        wait_ready("error");
        bus.in_valid = 1'b1;
        bus.hand_a = 2'b01; bus.hand_b = 2'b00; bus.hand_c = 2'b11;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if ({obs(), bus.frame_err} !== 6'b000001) begin
            n_bad++; $display("FAIL err_pulse: got %b required 000001", {obs(), bus.frame_err});
        end
        tick();
        n_cmp++;
        if ({obs(), bus.frame_err} !== 6'b000000) begin
            n_bad++; $display("FAIL err_after: got %b required 000000", {obs(), bus.frame_err});
        end
        tick();
        n_cmp++;
        if ({obs(), bus.frame_err} !== 6'b000010) begin
            n_bad++; $display("FAIL err_idle: got %b required 000010", {obs(), bus.frame_err});
        end
        n_cmp++;
        if (bus.round_cnt !== 4'd1) begin
            n_bad++; $display("FAIL err_cnt: got %0d required 1", bus.round_cnt);
        end
    endtask

    task automatic test_hold();
        wait_ready("hold");
        bus.in_valid = 1'b1;
        bus.hand_a = 2'b10; bus.hand_b = 2'b11; bus.hand_c = 2'b01;
        tick();
        bus.hand_a = 2'b11; bus.hand_b = 2'b01; bus.hand_c = 2'b10;
        n_cmp++;
        if (obs() !== 5'b11010) begin
            n_bad++; $display("FAIL hold_msb: got %b required 11010", obs());
        end
        tick();
        n_cmp++;
        if (obs() !== 5'b01110) begin
            n_bad++; $display("FAIL hold_lsb: got %b required 01110", obs());
        end
        if (P == 1) begin
            tick();
            n_cmp++;
            if (obs() !== 5'b01010) begin
                n_bad++; $display("FAIL hold_par: got %b required 01010", obs());
            end
        end
        for (int g = 0; g < 2; g++) begin
            tick();
            n_cmp++;
            if (obs() !== 5'b00000) begin
                n_bad++; $display("FAIL hold_gap%0d: got %b required 00000", g, obs());
            end
        end
        tick();
        n_cmp++;
        if (obs() !== 5'b00001) begin
            n_bad++; $display("FAIL hold_idle: got %b required 00001", obs());
        end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (obs() !== 5'b10110) begin
            n_bad++; $display("FAIL hold2_msb: got %b required 10110", obs());
        end
        tick();
        n_cmp++;
        if (obs() !== 5'b11010) begin
            n_bad++; $display("FAIL hold2_lsb: got %b required 11010", obs());
        end
        if (P == 1) begin
            tick();
            n_cmp++;
            if (obs() !== 5'b10010) begin
                n_bad++; $display("FAIL hold2_par: got %b required 10010", obs());
            end
        end
        tick();
        n_cmp++;
        if (bus.round_cnt !== 4'd3) begin
            n_bad++; $display("FAIL hold_cnt: got %0d required 3", bus.round_cnt);
        end
    endtask

    task automatic test_reset_mid();
        wait_ready("midrst");
        bus.in_valid = 1'b1;
        bus.hand_a = 2'b01; bus.hand_b = 2'b10; bus.hand_c = 2'b11;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== 5'b10110) begin
            n_bad++; $display("FAIL midrst_lsb: got %b required 10110", obs());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL midrst_lines: got %b required 00000", obs());
        end
        n_cmp++;
        if (bus.round_cnt !== 4'd0) begin
            n_bad++; $display("FAIL midrst_cnt: got %0d required 0", bus.round_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wait_ready("midrst_after");
        bus.in_valid = 1'b1;
        bus.hand_a = 2'b11; bus.hand_b = 2'b11; bus.hand_c = 2'b11;
        tick();
        bus.in_valid = 1'b0;
        for (int d = 0; d < 2 + P; d++) begin
            n_cmp++;
            if (obs() !== 5'b11110) begin
                n_bad++; $display("FAIL midrst_data%0d: got %b required 11110", d, obs());
            end
            tick();
        end
        n_cmp++;
        if (bus.round_cnt !== 4'd1) begin
            n_bad++; $display("FAIL midrst_newcnt: got %0d required 1", bus.round_cnt);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [3:0] exp_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wait_ready("wrap");
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.hand_a = 2'b10; bus.hand_b = 2'b01; bus.hand_c = 2'b11;
            tick();
            bus.in_valid = 1'b0;
            n_cmp++;
            if (obs() !== 5'b10110) begin
                n_bad++; $display("FAIL wrap_msb%0d: got %b required 10110", i, obs());
            end
            repeat (2 + P) tick();
            exp_cnt = 4'(i + 1);
            n_cmp++;
            if (bus.round_cnt !== exp_cnt) begin
                n_bad++; $display("FAIL wrap_cnt%0d: got %0d required %0d", i, bus.round_cnt, exp_cnt);
            end
            tick();
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_bad++; $display("FAIL wrap_gap%0d: got in_ready=%b required 0", i, bus.in_ready);
            end
            tick();
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_bad++; $display("FAIL wrap_ready%0d: got in_ready=%b required 1", i, bus.in_ready);
            end
        end
        n_cmp++;
        if (bus.round_cnt !== 4'd0) begin
            n_bad++; $display("FAIL wrap_final: got %0d required 0", bus.round_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_error();
        test_hold();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
